// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block: lock FSM encoding, default
// 640x480@60 timing totals and counter widths.
package vga_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int XCNT_W = 10;
    localparam int YCNT_W = 10;
    localparam int RGB_W  = 24;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// One input register stage plus its delayed copy; fall pulses for one cycle
// when the registered sample goes 1 -> 0.
module vga_edge_det #(
    parameter logic IDLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic q;
    logic q_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= IDLE;
            q_d <= IDLE;
        end else begin
            q   <= din;
            q_d <= q;
        end
    end

    assign fall = q_d & ~q;

endmodule

// File: rtl/vga_capture.sv
// Measures incoming VGA timing, locks onto the expected line/frame totals and
// emits captured active pixels with their coordinates while locked.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL_EXP = H_TOTAL,
    parameter int V_TOTAL_EXP = V_TOTAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hs,
    input  logic              vs,
    input  logic              blank_n,
    input  logic [7:0]        VGA_R,
    input  logic [7:0]        VGA_G,
    input  logic [7:0]        VGA_B,
    output logic              pix_valid,
    output logic [XCNT_W-1:0] pix_x,
    output logic [YCNT_W-1:0] pix_y,
    output logic [RGB_W-1:0]  pix_rgb,
    output logic              frame_start,
    output logic              locked,
    output logic [HCNT_W-1:0] h_meas,
    output logic [VCNT_W-1:0] v_meas,
    output logic              err
);

    localparam logic [HCNT_W-1:0] H_EXP = HCNT_W'(H_TOTAL_EXP);
    localparam logic [VCNT_W-1:0] V_EXP = VCNT_W'(V_TOTAL_EXP);

    logic              hs_fall;
    logic              vs_fall;
    logic              blank_r;
    logic [RGB_W-1:0]  rgb_r;

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic [XCNT_W-1:0] xcnt;
    logic [YCNT_W-1:0] ycnt;
    logic              line_active;

    logic              hcnt_max;
    logic [HCNT_W-1:0] hcnt_p1;
    logic              h_bad;
    logic              v_bad;
    logic [VCNT_W-1:0] v_base;
    logic [VCNT_W-1:0] vcnt_next;
    logic [XCNT_W-1:0] x_base;
    logic [XCNT_W-1:0] xcnt_next;
    logic [YCNT_W-1:0] y_now;
    logic              line_active_next;

    lock_state_t       state;
    lock_state_t       state_next;
    logic              mismatch;
    logic              mismatch_next;
    logic              err_next;

    vga_edge_det #(.IDLE(1'b1)) u_hs_edge (
        .clk  (clk),
        .reset(reset),
        .din  (hs),
        .fall (hs_fall)
    );

    vga_edge_det #(.IDLE(1'b1)) u_vs_edge (
        .clk  (clk),
        .reset(reset),
        .din  (vs),
        .fall (vs_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_r <= 1'b0;
            rgb_r   <= '0;
        end else begin
            blank_r <= blank_n;
            rgb_r   <= {VGA_R, VGA_G, VGA_B};
        end
    end

    // vs_fall is applied before hs_fall, so a coincident pair leaves vcnt at 1.
    always_comb begin
        hcnt_max         = &hcnt;
        hcnt_p1          = hcnt_max ? hcnt : hcnt + 1'b1;
        h_bad            = hs_fall && (hcnt_p1 != H_EXP);
        v_bad            = vs_fall && (vcnt != V_EXP);
        v_base           = vs_fall ? '0 : vcnt;
        vcnt_next        = (hs_fall && !(&v_base)) ? v_base + 1'b1 : v_base;
        x_base           = hs_fall ? '0 : xcnt;
        xcnt_next        = (blank_r && !(&x_base)) ? x_base + 1'b1 : x_base;
        y_now            = vs_fall ? '0
                         : (hs_fall && line_active && !(&ycnt)) ? ycnt + 1'b1 : ycnt;
        line_active_next = blank_r | (line_active & ~hs_fall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            xcnt        <= '0;
            ycnt        <= '0;
            line_active <= 1'b0;
            h_meas      <= '0;
            v_meas      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (hs_fall) begin
                hcnt   <= '0;
                h_meas <= hcnt_p1;
            end else if (!hcnt_max) begin
                hcnt <= hcnt + 1'b1;
            end
            if (vs_fall) begin
                v_meas <= vcnt;
            end
            vcnt        <= vcnt_next;
            xcnt        <= xcnt_next;
            ycnt        <= y_now;
            line_active <= line_active_next;
            frame_start <= vs_fall;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            mismatch <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            mismatch <= mismatch_next;
            err      <= err_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        mismatch_next = mismatch;
        err_next      = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_next    = CHECK;
                    mismatch_next = 1'b0;
                end
            end
            CHECK: begin
                if (vs_fall) begin
                    if (!mismatch && !h_bad && !v_bad) begin
                        state_next = LOCKED;
                    end
                    mismatch_next = 1'b0;
                end else if (h_bad) begin
                    mismatch_next = 1'b1;
                end
            end
            LOCKED: begin
                if (h_bad || v_bad || hcnt_max) begin
                    state_next = SEARCH;
                    err_next   = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_rgb   <= '0;
        end else begin
            pix_valid <= blank_r && locked;
            if (blank_r && locked) begin
                pix_x   <= x_base;
                pix_y   <= y_now;
                pix_rgb <= rgb_r;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture: a scaled-down raster with random pixel
// colours, a long line, a sync timeout and a mid-frame reset.
module tb_vga_capture;

    localparam int H_TOT       = 200;
    localparam int H_SYNC      = 24;
    localparam int H_ACT_START = 36;
    localparam int H_ACT       = 160;
    localparam int V_TOT       = 20;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 4;
    localparam int V_ACT       = 12;
    localparam int LONG_LINE   = 2200;
    localparam int RST_CYCLE   = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        blank_n = 1'b0;
    logic [7:0]  r = 8'd0;
    logic [7:0]  g = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic [10:0] h_meas;
    logic [9:0]  v_meas;
    logic        err;

    vga_capture #(
        .H_TOTAL_EXP(H_TOT),
        .V_TOTAL_EXP(V_TOT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .blank_n    (blank_n),
        .VGA_R      (r),
        .VGA_G      (g),
        .VGA_B      (b),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_start(frame_start),
        .locked     (locked),
        .h_meas     (h_meas),
        .v_meas     (v_meas),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } pix_t;

    pix_t pq[$];
    pix_t pe;

    // Frame-level reference: lock holds once two vs_falls have passed since
    // the last reset or malformed line.
    int vs_since = 0;
    int lines_since = 0;
    int v_exp = 0;
    int h_exp = 0;
    int err_exp = 0;
    int fs_exp = 0;
    int prev_len = 0;
    bit prev_full = 1'b0;
    bit prev_bad = 1'b0;
    bit h_known = 1'b0;
    bit lk = 1'b0;

    int err_cnt = 0;
    int fs_cnt = 0;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            check("pix_late", 64'(cyc), 64'(pq[0].cyc));
            void'(pq.pop_front());
        end
        if (pix_valid === 1'b1) begin
            if (pq.size() == 0) begin
                check("pix_spurious", 64'(pix_valid), 64'd0);
            end else begin
                pe = pq.pop_front();
                check("pix_cycle", 64'(cyc), 64'(pe.cyc));
                check("pix_xy_rgb", 64'({pix_x, pix_y, pix_rgb}), 64'({pe.x, pe.y, pe.rgb}));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
        check({tag, "_pix_x"}, 64'(pix_x), 64'd0);
        check({tag, "_pix_y"}, 64'(pix_y), 64'd0);
        check({tag, "_pix_rgb"}, 64'(pix_rgb), 64'd0);
        check({tag, "_h_meas"}, 64'(h_meas), 64'd0);
        check({tag, "_v_meas"}, 64'(v_meas), 64'd0);
    endtask

    task automatic drive_line(input int line, input int len, input int rst_at);
        logic [23:0] rgb_v;
        bit          act_line;
        if (prev_bad && vs_since >= 2) err_exp++;
        if (prev_bad) vs_since = 0;
        if (line == 0) begin
            v_exp = lines_since;
            lines_since = 1;
            vs_since++;
            fs_exp++;
        end else begin
            lines_since++;
        end
        h_known   = prev_full;
        h_exp     = (prev_len > 2047) ? 2047 : prev_len;
        prev_bad  = (len != H_TOT);
        prev_len  = len;
        prev_full = 1'b1;
        lk        = (vs_since >= 2);
        act_line  = (line >= V_ACT_START) && (line < V_ACT_START + V_ACT);

        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            if (c == H_SYNC) begin
                check("locked", 64'(locked), 64'(lk));
                check("err_count", 64'(err_cnt), 64'(err_exp));
                check("frame_start_count", 64'(fs_cnt), 64'(fs_exp));
                check("v_meas", 64'(v_meas), 64'(v_exp));
                if (h_known) check("h_meas", 64'(h_meas), 64'(h_exp));
            end
            if (rst_at >= 0 && c == rst_at + 1) begin
                check_all_zero("midframe_reset");
                vs_since    = 0;
                lines_since = 0;
                v_exp       = 0;
                prev_full   = 1'b0;
                lk          = 1'b0;
            end
            reset   = (c == rst_at);
            hs      = (c < H_SYNC) ? 1'b0 : 1'b1;
            vs      = (line < V_SYNC) ? 1'b0 : 1'b1;
            blank_n = act_line && (c >= H_ACT_START) && (c < H_ACT_START + H_ACT);
            rgb_v   = 24'($urandom);
            if (line == V_ACT_START && c == H_ACT_START) rgb_v = 24'hAAAAAA;
            {r, g, b} = rgb_v;
            if (blank_n && lk) begin
                pq.push_back('{cyc + 2, 10'(c - H_ACT_START), 10'(line - V_ACT_START), rgb_v});
            end
        end
    endtask

    task automatic drive_frame(input int bad_line, input int bad_len, input int rst_line);
        for (int l = 0; l < V_TOT; l++) begin
            drive_line(l, (l == bad_line) ? bad_len : H_TOT, (l == rst_line) ? RST_CYCLE : -1);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (10) @(posedge clk);

        repeat (3) drive_frame(-1, 0, -1);
        drive_frame(int'($urandom_range(V_TOT - 3, 2)), H_TOT + 1, -1);
        repeat (2) drive_frame(-1, 0, -1);
        drive_frame(int'($urandom_range(18, 16)), LONG_LINE, -1);
        repeat (2) drive_frame(-1, 0, -1);
        drive_frame(-1, 0, V_TOT / 2);
        repeat (3) drive_frame(-1, 0, -1);

        repeat (6) @(posedge clk);
        #1;
        check("locked_end", 64'(locked), 64'(vs_since >= 2));
        check("err_count_end", 64'(err_cnt), 64'(err_exp));
        check("pix_queue_empty", 64'(pq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
